// File: rtl/uart_tx_queue.sv
// UART transmit queue: byte FIFO feeding a tx_en/tx_busy/tx_done launch FSM; optional UART_TXQ_WATERMARK_EN adds low_wm/txq_low.
// Latency: a push into an idle empty queue raises tx_en one edge later; the next frame launches one edge after tx_done.
// Backpressure: wr_ready drops when full; a push while full is dropped and sets the sticky overflow flag.
module uart_tx_queue #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 wr_valid,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 flush,
    input  logic                 clr_ovf,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 tx_en,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 empty,
    output logic                 full,
    output logic [LVL_W-1:0]     level,
    output logic                 overflow,
`ifdef UART_TXQ_WATERMARK_EN
    input  logic [LVL_W-1:0]     low_wm,
    output logic                 txq_low,
`endif
    output logic                 active
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 push, pop, load;

    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign wr_ready = !full;
    assign tx_en    = (state == START);
    assign active   = (state != IDLE);

    // flush outranks both push and pop so a flushed cycle never moves data
    assign push = wr_valid && !full && !flush;
    assign pop  = load;

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // set wins over a coincident clear
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            overflow <= 1'b0;
        end else if (wr_valid && full && !flush) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) tx_data <= mem[rd_ptr];
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    state_nxt = START;
                    load      = 1'b1;
                end
            end
            START: begin
                if (tx_done)      state_nxt = IDLE;
                else if (tx_busy) state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_TXQ_WATERMARK_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            txq_low <= 1'b1;
        end else begin
            txq_low <= (level <= low_wm);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: reset, single frame, ordering, overflow, flush, async reset mid-frame.
module tb_uart_tx_queue;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       wr_ready, tx_en, empty, full, overflow, active;
    logic [7:0] tx_data;
    logic [4:0] level;
`ifdef UART_TXQ_WATERMARK_EN
    logic [4:0] low_wm = 5'd2;
    logic       txq_low;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_queue #(.DATA_BITS(8), .DEPTH(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .flush(flush), .clr_ovf(clr_ovf),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_en(tx_en), .tx_data(tx_data),
        .empty(empty), .full(full), .level(level), .overflow(overflow),
`ifdef UART_TXQ_WATERMARK_EN
        .low_wm(low_wm), .txq_low(txq_low),
`endif
        .active(active)
    );

    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL rst_tx_en got %0h exp 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %0h exp 0", tx_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0h exp 0", overflow); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty got %0h exp 1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full got %0h exp 0", full); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %0h exp 1", wr_ready); end
        checks++; if (active !== 1'b0)   begin errors++; $display("FAIL rst_active got %0h exp 0", active); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
`ifdef UART_TXQ_WATERMARK_EN
        checks++; if (txq_low !== 1'b1)  begin errors++; $display("FAIL rst_txq_low got %0h exp 1", txq_low); end
`endif
        step();
        PRESET = 1'b0;
        step();
    endtask

    task automatic test_single();
        push(8'hA5);
        checks++; if (level !== 5'd1)  begin errors++; $display("FAIL single_level_push got %0d exp 1", level); end
        checks++; if (tx_en !== 1'b0)  begin errors++; $display("FAIL single_no_fallthrough got %0h exp 0", tx_en); end
        step();
        checks++; if (tx_en !== 1'b1)    begin errors++; $display("FAIL single_tx_en got %0h exp 1", tx_en); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data got %0h exp a5", tx_data); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL single_level_pop got %0d exp 0", level); end
        tx_busy = 1'b1;
        step();
        checks++; if (tx_en !== 1'b0)  begin errors++; $display("FAIL single_tx_en_drop got %0h exp 0", tx_en); end
        step();
        step();
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active_wait got %0h exp 1", active); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data_hold got %0h exp a5", tx_data); end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_active_end got %0h exp 0", active); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            while (tx_en !== 1'b1 && n < 20) begin step(); n++; end
            checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL b2b_launch_timeout frame %0d got %0h exp 1", k, tx_en); end
            checks++; if (tx_data !== exp_b[k]) begin errors++; $display("FAIL b2b_order frame %0d got %0h exp %0h", k, tx_data, exp_b[k]); end
            tx_busy = 1'b1;
            step();
            checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL b2b_tx_en_drop frame %0d got %0h exp 0", k, tx_en); end
            repeat (9) step();
            tx_busy = 1'b0;
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++; if (tx_en !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_done frame %0d got en=%0h act=%0h exp en=0 act=0", k, tx_en, active); end
            if (k < 2) begin
                step();
                checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL b2b_relaunch_2edges frame %0d got %0h exp 1", k, tx_en); end
            end
        end
        checks++; if (empty !== 1'b1 || active !== 1'b0) begin errors++; $display("FAIL b2b_end got empty=%0h act=%0h exp empty=1 act=0", empty, active); end
    endtask

    task automatic test_overflow();
        tx_busy = 1'b1;
        push(8'h00);
        step();
        step();
        checks++; if (active !== 1'b1 || tx_en !== 1'b0) begin errors++; $display("FAIL ovf_hold_wait got act=%0h en=%0h exp act=1 en=0", active, tx_en); end
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        checks++; if (level !== 5'd16)   begin errors++; $display("FAIL ovf_level_full got %0d exp 16", level); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full got %0h exp 1", full); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ovf_wr_ready got %0h exp 0", wr_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got %0h exp 0", overflow); end
        push(8'hEE);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0h exp 1", overflow); end
        checks++; if (level !== 5'd16)   begin errors++; $display("FAIL ovf_level_unchanged got %0d exp 16", level); end
        clr_ovf = 1'b1;
        push(8'hEF);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0h exp 1", overflow); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0h exp 0", overflow); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_flush_level got %0d exp 0", level); end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        step();
        checks++; if (tx_en !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL ovf_quiet_end got en=%0h act=%0h exp 0 0", tx_en, active); end
    endtask

    task automatic test_flush();
        logic seen;
        tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) push(8'(i));
        checks++; if (level !== 5'd4)     begin errors++; $display("FAIL flush_pre_level got %0d exp 4", level); end
        checks++; if (tx_data !== 8'h01)  begin errors++; $display("FAIL flush_pre_tx_data got %0h exp 01", tx_data); end
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h7E;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level got lvl=%0d empty=%0h exp 0 1", level, empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_no_ovf got %0h exp 0", overflow); end
        checks++; if (active !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL flush_inflight got act=%0h data=%0h exp 1 01", active, tx_data); end
        step();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_push_dropped got %0d exp 0", level); end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL flush_frame_done got %0h exp 0", active); end
        seen = 1'b0;
        repeat (5) begin
            step();
            if (tx_en === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_relaunch got %0h exp 0", seen); end
    endtask

    task automatic test_reset_mid();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
        checks++; if (level !== 5'd3 || active !== 1'b1 || tx_data !== 8'hC1) begin errors++; $display("FAIL rmid_pre got lvl=%0d act=%0h data=%0h exp 3 1 c1", level, active, tx_data); end
        #2;
        PRESET = 1'b1;
        #1;
        checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL rmid_tx_en got %0h exp 0", tx_en); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL rmid_level got %0d exp 0", level); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rmid_empty got %0h exp 1", empty); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data got %0h exp 0", tx_data); end
        checks++; if (active !== 1'b0)   begin errors++; $display("FAIL rmid_active got %0h exp 0", active); end
        step();
        PRESET  = 1'b0;
        tx_busy = 1'b0;
        step();
        step();
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL rmid_no_launch got %0h exp 0", tx_en); end
    endtask

`ifdef UART_TXQ_WATERMARK_EN
    task automatic test_watermark();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
        checks++; if (level !== 5'd3 || txq_low !== 1'b1) begin errors++; $display("FAIL wm_at3_lag got lvl=%0d low=%0h exp 3 1", level, txq_low); end
        step();
        checks++; if (txq_low !== 1'b0) begin errors++; $display("FAIL wm_low_clear got %0h exp 0", txq_low); end
        push(8'h94);
        tx_busy = 1'b0;
        repeat (2) begin
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            step();
        end
        checks++; if (level !== 5'd2 || txq_low !== 1'b0) begin errors++; $display("FAIL wm_at2_lag got lvl=%0d low=%0h exp 2 0", level, txq_low); end
        step();
        checks++; if (txq_low !== 1'b1) begin errors++; $display("FAIL wm_low_set got %0h exp 1", txq_low); end
        flush   = 1'b1;
        tx_done = 1'b1;
        step();
        flush   = 1'b0;
        tx_done = 1'b0;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL wm_cleanup got %0h exp 0", active); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid();
`ifdef UART_TXQ_WATERMARK_EN
        test_watermark();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
